// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns per-byte SPI chip-select frames into 3-frame register transactions.
// Optional feature macro: SPI_CTRL_TIMEOUT_EN (idle timeout counter, IDLE resync, frame_err).
module spi_reg_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter logic [7:0]  ACK_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic [7:0] slave_paraout,
  output logic       slave_write,
  output logic [7:0] slave_parain,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_A, S_B, S_C} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_cs_q;
  logic       r_fall_d;
  logic       r_rw;
  logic       r_rd_pend;
  logic [6:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_parain;

  logic       w_fall;
  logic       w_timeout;
  logic       w_we;
  logic       w_re;
  logic       w_rw_nxt;
  logic       w_rd_pend_nxt;
  logic [6:0] w_addr_nxt;
  logic [7:0] w_wdata_nxt;
  logic [7:0] w_parain_nxt;

  assign w_fall = r_cs_q & ~cs;

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(IDLE_TIMEOUT);

  logic [15:0] r_to_cnt;
  logic        r_frame_err;
  logic        w_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (!cs) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LIMIT) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
    end
  end

  // A cs fall in the timeout cycle takes priority over the resync.
  assign w_timeout = (r_to_cnt == TO_LIMIT) && !w_fall;
  assign frame_err = r_frame_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |IDLE_TIMEOUT;
  assign w_timeout        = 1'b0;
  assign frame_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_we          = 1'b0;
    w_re          = 1'b0;
    w_rw_nxt      = r_rw;
    w_rd_pend_nxt = 1'b0;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_parain_nxt  = r_parain;
`ifdef SPI_CTRL_TIMEOUT_EN
    w_err         = 1'b0;
`endif

    if (r_rd_pend) begin
      w_parain_nxt = reg_rdata;
    end

`ifdef SPI_CTRL_TIMEOUT_EN
    if (w_timeout && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      if (r_state != S_C) begin
        w_err        = 1'b1;
        w_parain_nxt = '0;
      end
    end else
`endif
    if (r_fall_d) begin
      unique case (r_state)
        S_IDLE, S_C: begin
          w_state_nxt = S_A;
        end
        S_A: begin
          w_state_nxt = S_B;
          w_addr_nxt  = slave_paraout[6:0];
          w_rw_nxt    = slave_paraout[7];
          if (slave_paraout[7]) begin
            w_parain_nxt = ACK_BYTE;
          end else begin
            w_re          = 1'b1;
            w_rd_pend_nxt = 1'b1;
          end
        end
        S_B: begin
          w_state_nxt  = S_C;
          w_parain_nxt = '0;
          if (r_rw) begin
            w_we        = 1'b1;
            w_wdata_nxt = slave_paraout;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_q    <= 1'b0;
      r_fall_d  <= 1'b0;
      r_rw      <= 1'b0;
      r_rd_pend <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_parain  <= '0;
    end else begin
      r_cs_q    <= cs;
      r_fall_d  <= w_fall;
      r_rw      <= w_rw_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_parain  <= w_parain_nxt;
    end
  end

  // Strobes fire in the fall_d cycle, so address and data bypass their latches then.
  assign reg_addr     = w_addr_nxt;
  assign reg_wdata    = w_wdata_nxt;
  assign reg_we       = w_we & rst_n;
  assign reg_re       = w_re & rst_n;
  assign slave_write  = 1'b1;
  assign slave_parain = r_parain;
  assign busy         = (r_state == S_A) || (r_state == S_B);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: SPI slave and register bank models, vector table,
// corner-case sequences and randomized transactions against a transaction-level model.
module tb_spi_reg_ctrl;

  localparam int unsigned TO  = 40;
  localparam logic [7:0]  ACK = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic [7:0] slave_paraout = 8'h00;
  logic [7:0] reg_rdata = 8'h00;
  logic       slave_write;
  logic [7:0] slave_parain;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic       busy;
  logic       frame_err;

  always #5 clk = ~clk;

  spi_reg_ctrl #(
    .IDLE_TIMEOUT(TO),
    .ACK_BYTE    (ACK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .slave_paraout(slave_paraout),
    .slave_write  (slave_write),
    .slave_parain (slave_parain),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Register bank: preloaded once, read data valid the cycle after reg_re.
  logic [7:0] bank [128];
  logic       bank_ready = 1'b0;
  always @(posedge clk) begin
    if (!rst_n && !bank_ready) begin
      for (int i = 0; i < 128; i++) bank[i] <= (i == 18) ? 8'h5A : 8'(i * 7 + 3);
      bank_ready <= 1'b1;
    end else if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_re ? bank[reg_addr] : 8'hEE;
  end

  // SPI slave: at each cs fall, expose the previous frame's byte and load the transmit byte.
  logic       slv_cs_q = 1'b1;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] miso_q [$];
  always @(posedge clk) begin
    slv_cs_q <= cs;
    if (slv_cs_q && !cs) begin
      slave_paraout <= last_byte;
      miso_q.push_back(slave_parain);
    end
  end

  int         n_we = 0, n_re = 0, n_err = 0, n_overlap = 0, n_swlow = 0;
  logic [6:0] we_addr = '0, re_addr = '0;
  logic [7:0] we_data = '0;
  always @(negedge clk) begin
    if (reg_we) begin n_we++; we_addr = reg_addr; we_data = reg_wdata; end
    if (reg_re) begin n_re++; re_addr = reg_addr; end
    if (reg_we && reg_re) n_overlap++;
    if (frame_err) n_err++;
    if (slave_write !== 1'b1) n_swlow++;
  end

  logic [7:0] ref_mem [128];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] trl;
    logic       ewe;
    logic       ere;
    logic [6:0] eaddr;
    logic [7:0] ewdata;
    logic [7:0] emiso;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Starts and ends just after a negedge; cs stays high for exactly hi sampled edges.
  task automatic do_frame(input logic [7:0] b, input int lo, input int hi, output logic bsy);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    bsy = busy;
    repeat (lo - 3) @(negedge clk);
    cs = 1'b1;
    last_byte = b;
    repeat (hi) @(negedge clk);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                         input logic [7:0] trl, input int lo, input int hi, input int hi_last,
                         input logic ewe, input logic ere, input logic [6:0] eaddr,
                         input logic [7:0] ewdata, input logic [7:0] emiso);
    int   we0, re0, err0, q0;
    logic b0, b1, b2;
    we0 = n_we; re0 = n_re; err0 = n_err; q0 = miso_q.size();
    do_frame(cmd, lo, hi, b0);
    do_frame(data, lo, hi, b1);
    do_frame(trl, lo, hi_last, b2);
    check({tag, ".we_cnt"}, 32'(n_we - we0), 32'(ewe));
    check({tag, ".re_cnt"}, 32'(n_re - re0), 32'(ere));
    check({tag, ".err_cnt"}, 32'(n_err - err0), 32'd0);
    check({tag, ".busy"}, 32'({b0, b1, b2}), 32'(3'b110));
    if (ewe) begin
      check({tag, ".we_addr"}, 32'(we_addr), 32'(eaddr));
      check({tag, ".we_data"}, 32'(we_data), 32'(ewdata));
    end
    if (ere) check({tag, ".re_addr"}, 32'(re_addr), 32'(eaddr));
    if (miso_q.size() >= q0 + 3) begin
      check({tag, ".miso0"}, 32'(miso_q[q0]), 32'h00);
      check({tag, ".miso1"}, 32'(miso_q[q0 + 1]), 32'h00);
      check({tag, ".miso2"}, 32'(miso_q[q0 + 2]), 32'(emiso));
    end else begin
      check({tag, ".miso_frames"}, 32'(miso_q.size() - q0), 32'd3);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".slave_write"}, 32'(slave_write), 32'd1);
    check({tag, ".parain"}, 32'(slave_parain), 32'h00);
    check({tag, ".addr"}, 32'(reg_addr), 32'h00);
    check({tag, ".wdata"}, 32'(reg_wdata), 32'h00);
    check({tag, ".we"}, 32'(reg_we), 32'd0);
    check({tag, ".re"}, 32'(reg_re), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=time limit reached required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         we0, re0, err0, q0;
    logic       b0, b1, b2;
    logic [7:0] c, d, t, em;
    logic [6:0] a;
    logic       ewe, ere;
    int         hl;

    for (int i = 0; i < 128; i++) ref_mem[i] = (i == 18) ? 8'h5A : 8'(i * 7 + 3);

    vt[0] = '{8'h85, 8'h3C, 8'h00, 1'b1, 1'b0, 7'h05, 8'h3C, ACK};
    vt[1] = '{8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 7'h12, 8'h00, 8'h5A};
    vt[2] = '{8'h81, 8'hC3, 8'h00, 1'b1, 1'b0, 7'h01, 8'hC3, ACK};
    vt[3] = '{8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 7'h01, 8'h00, 8'hC3};
    vt[4] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 7'h7F, 8'hFF, ACK};
    vt[5] = '{8'h7F, 8'hAA, 8'h55, 1'b0, 1'b1, 7'h7F, 8'h00, 8'hFF};
    vt[6] = '{8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 7'h00, 8'h00, ACK};
    vt[7] = '{8'h00, 8'h11, 8'h22, 1'b0, 1'b1, 7'h00, 8'h00, 8'h00};

    rst_n = 1'b0;
    cs    = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("idle");

    // Back-to-back vectors at minimum frame timing, no idle gap.
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i].cmd, vt[i].data, vt[i].trl, 4, 4, 4,
              vt[i].ewe, vt[i].ere, vt[i].eaddr, vt[i].ewdata, vt[i].emiso);
      if (vt[i].cmd[7]) ref_mem[vt[i].cmd[6:0]] = vt[i].data;
    end

    // Abort after command and data frames, cs held high past the timeout.
    we0 = n_we; err0 = n_err;
    do_frame(8'h85, 4, 4, b0);
    do_frame(8'h3C, 4, int'(TO) + 10, b1);
    check("abort.we_cnt", 32'(n_we - we0), 32'd0);
`ifdef SPI_CTRL_TIMEOUT_EN
    check("abort.err_cnt", 32'(n_err - err0), 32'd1);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.parain", 32'(slave_parain), 32'h00);
    run_txn("post_abort", 8'h85, 8'h5E, 8'h00, 4, 4, 4, 1'b1, 1'b0, 7'h05, 8'h5E, ACK);
    ref_mem[5] = 8'h5E;
`else
    check("abort.err_cnt", 32'(n_err - err0), 32'd0);
    check("abort.busy", 32'(busy), 32'd1);
    q0 = miso_q.size();
    do_frame(8'h00, 4, 4, b2);
    check("noto.we_cnt", 32'(n_we - we0), 32'd1);
    check("noto.we_addr", 32'(we_addr), 32'h05);
    check("noto.we_data", 32'(we_data), 32'h3C);
    if (miso_q.size() > q0) check("noto.miso2", 32'(miso_q[q0]), 32'(ACK));
    else check("noto.miso_frames", 32'(miso_q.size() - q0), 32'd1);
    ref_mem[5] = 8'h3C;
`endif

    // cs fall lands in the cycle the timeout count is reached; then a long idle in state C.
    we0 = n_we; err0 = n_err;
    do_frame(8'h86, 4, 4, b0);
    do_frame(8'h99, 4, int'(TO), b1);
    do_frame(8'h00, 4, int'(TO) + 10, b2);
    check("fallwins.we_cnt", 32'(n_we - we0), 32'd1);
    check("fallwins.we_addr", 32'(we_addr), 32'h06);
    check("fallwins.we_data", 32'(we_data), 32'h99);
    check("fallwins.err_cnt", 32'(n_err - err0), 32'd0);
    check("fallwins.busy", 32'(busy), 32'd0);
    ref_mem[6] = 8'h99;

    // Reset while in state B of a write.
    we0 = n_we; re0 = n_re;
    do_frame(8'h85, 4, 4, b0);
    do_frame(8'h3C, 4, 4, b1);
    check("rstB.busy_before", 32'(busy), 32'd1);
    check("rstB.parain_before", 32'(slave_parain), 32'(ACK));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rstB");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstB.we_cnt", 32'(n_we - we0), 32'd0);
    check("rstB.re_cnt", 32'(n_re - re0), 32'd0);
    check("rstB.busy_after", 32'(busy), 32'd0);
    run_txn("post_rst", 8'h83, 8'h21, 8'h00, 4, 4, 4, 1'b1, 1'b0, 7'h03, 8'h21, ACK);
    ref_mem[3] = 8'h21;
    run_txn("post_rst_rd", 8'h05, 8'h00, 8'h00, 4, 4, 4, 1'b0, 1'b1, 7'h05, 8'h00, ref_mem[5]);

    // Randomized transactions against the transaction-level model.
    for (int k = 0; k < 40; k++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
      c  = {1'($urandom), a};
      d  = 8'($urandom);
      t  = 8'($urandom);
      hl = ($urandom_range(0, 7) == 0) ? int'(TO) + 5 : int'($urandom_range(4, 12));
      ewe = c[7];
      ere = ~c[7];
      em  = c[7] ? ACK : ref_mem[a];
      run_txn($sformatf("rnd%0d", k), c, d, t, int'($urandom_range(4, 7)),
              int'($urandom_range(4, 12)), hl, ewe, ere, a, d, em);
      if (c[7]) ref_mem[a] = d;
    end

    repeat (4) @(negedge clk);
    check("strobe_overlap", 32'(n_overlap), 32'd0);
    check("slave_write_low", 32'(n_swlow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
